// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//
// Shared types and constants for the data-memory arbiter slice:
//   - state_e / ST_* : sequencer states (IDLE, BUSY, DONE). The ST_* constants
//                      are plain 2-bit values so the state register can stay
//                      a simple logic vector.
//   - PORT_MEM/LDR   : requester indices (0 = pipeline MEM stage,
//                      1 = loader/debug port).
//   - op_e           : latched access type.
//   - addr_misaligned: helper used when the alignment check is compiled in.
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_DONE = DONE;

  localparam logic PORT_MEM = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Word accesses must sit on a 4-byte boundary.
  function automatic logic addr_misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//
// Bundles the two requester ports and the single memory port of the data
// memory arbiter.
//
// Handshake: a requester raises read and/or write together with stable
// addr/wdata and holds all of them until it sees its one-cycle done pulse.
// done is the only acknowledgement; there is no separate ready. When read
// and write are both high the access is a read. rdata is valid from the done
// cycle and holds until the next read on that port.
//
// Signals:
//   p0_* : pipeline MEM-stage requester (read, write, addr, wdata, rdata, done)
//   p1_* : loader/debug requester       (read, write, addr, wdata, rdata, done)
//   mem_*: memory strobes, address, write data, read data
//   err  : alignment error flag, high with done (alignment check builds only)
//
// Modports:
//   slave  : the arbiter side
//   master : the environment side (requesters + memory)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          p0_read;
  logic          p0_write;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic [DW-1:0] p0_rdata;
  logic          p0_done;

  logic          p1_read;
  logic          p1_write;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic [DW-1:0] p1_rdata;
  logic          p1_done;

  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          err;

  modport slave (
    input  p0_read, p0_write, p0_addr, p0_wdata,
    output p0_rdata, p0_done,
    input  p1_read, p1_write, p1_addr, p1_wdata,
    output p1_rdata, p1_done,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata,
    output err
  );

  modport master (
    output p0_read, p0_write, p0_addr, p0_wdata,
    input  p0_rdata, p0_done,
    output p1_read, p1_write, p1_addr, p1_wdata,
    input  p1_rdata, p1_done,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata,
    input  err
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//
// Two-way round-robin arbiter, purely combinational.
//
// Ports:
//   i_req[1:0]  : request vector (bit 0 = PORT_MEM, bit 1 = PORT_LDR)
//   i_last      : index of the port granted most recently
//   o_gnt[1:0]  : one-hot grant, all zero when nothing requests
//   o_gnt_idx   : index of the granted port (0 when nothing requests)
//
// A lone requester always wins. On contention the port that did not win
// last time is chosen, so each port waits for at most one foreign access.
// -----------------------------------------------------------------------------
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt,
  output logic       o_gnt_idx
);

  always_comb begin
    o_gnt     = 2'b00;
    o_gnt_idx = PORT_MEM;
    case (i_req)
      2'b01: begin
        o_gnt     = 2'b01;
        o_gnt_idx = PORT_MEM;
      end
      2'b10: begin
        o_gnt     = 2'b10;
        o_gnt_idx = PORT_LDR;
      end
      2'b11: begin
        if (i_last == PORT_MEM) begin
          o_gnt     = 2'b10;
          o_gnt_idx = PORT_LDR;
        end else begin
          o_gnt     = 2'b01;
          o_gnt_idx = PORT_MEM;
        end
      end
      default: begin
        o_gnt     = 2'b00;
        o_gnt_idx = PORT_MEM;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Arbiter and access sequencer in front of the single-port data memory.
// Port 0 is the pipeline MEM stage, port 1 the loader/debug port. Accesses
// are serialised: one grant is taken in IDLE, the memory strobe is held for
// 1 + WAIT_CYCLES cycles in BUSY, and the granted port gets a one-cycle done
// pulse in DONE. Request at cycle t -> strobes t+1..t+1+WAIT_CYCLES,
// done at t+2+WAIT_CYCLES, next grant no earlier than t+3+WAIT_CYCLES.
//
// Parameters:
//   AW          : address width
//   DW          : data width
//   WAIT_CYCLES : extra strobe cycles beyond the first (0..15)
//
// Ports:
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   bus         : dmem_arbiter_if.slave (requesters, memory port, err)
//   o_dbg_state : current sequencer state (ST_* encoding)
//
// Build option:
//   DMEM_ARB_ALIGN_CHECK_EN : when defined, a granted access whose
//   addr[1:0] != 0 skips BUSY, never raises a strobe, and completes with
//   err high in the done cycle. When undefined err is tied 0 and every
//   address is passed through as given.
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus,
  output logic [1:0]    o_dbg_state
);

  localparam logic [3:0] LP_WAIT = WAIT_CYCLES[3:0];

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]    r_state;
  logic          r_last;     // most recently granted port
  logic [3:0]    r_cnt;      // remaining extra strobe cycles
  logic          r_gnt;      // port owning the current access
  op_e           r_op;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_p0_rdata;
  logic [DW-1:0] r_p1_rdata;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic          r_err;      // current access was rejected as misaligned
`endif

  // ---------------------------------------------------------------------------
  // Arbitration and operand selection
  // ---------------------------------------------------------------------------
  logic [1:0]    w_req;
  logic [1:0]    w_gnt;
  logic          w_gnt_idx;
  logic          w_sel_read;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  assign w_req = {bus.p1_read | bus.p1_write, bus.p0_read | bus.p0_write};

  rr_arb2 u_rr_arb2 (
    .i_req     (w_req),
    .i_last    (r_last),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  // Read wins when a port raises both read and write.
  assign w_sel_read  = (w_gnt[0] & bus.p0_read) | (w_gnt[1] & bus.p1_read);
  assign w_sel_addr  = w_gnt[1] ? bus.p1_addr  : bus.p0_addr;
  assign w_sel_wdata = w_gnt[1] ? bus.p1_wdata : bus.p0_wdata;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic w_misalign;
  assign w_misalign = addr_misaligned(w_sel_addr[1:0]);
`endif

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_last     <= PORT_LDR;   // so port 0 wins the first contended grant
      r_cnt      <= 4'd0;
      r_gnt      <= PORT_MEM;
      r_op       <= OP_RD;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      r_err      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_gnt   <= w_gnt_idx;
            r_last  <= w_gnt_idx;
            r_op    <= w_sel_read ? OP_RD : OP_WR;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_cnt   <= LP_WAIT;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            // A misaligned access is acknowledged without touching memory.
            if (w_misalign) begin
              r_err   <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_err   <= 1'b0;
              r_state <= ST_BUSY;
            end
`else
            r_state <= ST_BUSY;
`endif
          end
        end

        ST_BUSY: begin
          // Memory read data is sampled on the last strobe cycle only.
          if (r_cnt == 4'd0) begin
            if (r_op == OP_RD) begin
              if (r_gnt == PORT_MEM) begin
                r_p0_rdata <= bus.mem_rdata;
              end else begin
                r_p1_rdata <= bus.mem_rdata;
              end
            end
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        ST_DONE: begin
          // Requests present here are left for the next IDLE cycle.
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from registers so reset clears them immediately)
  // ---------------------------------------------------------------------------
  assign bus.mem_read  = (r_state == ST_BUSY) && (r_op == OP_RD);
  assign bus.mem_write = (r_state == ST_BUSY) && (r_op == OP_WR);
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

  assign bus.p0_done   = (r_state == ST_DONE) && (r_gnt == PORT_MEM);
  assign bus.p1_done   = (r_state == ST_DONE) && (r_gnt == PORT_LDR);
  assign bus.p0_rdata  = r_p0_rdata;
  assign bus.p1_rdata  = r_p1_rdata;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign bus.err = (r_state == ST_DONE) && r_err;
`else
  assign bus.err = 1'b0;
`endif

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Bench for dmem_arbiter with WAIT_CYCLES = 2. A transaction-level model
// schedules each granted access on a timeline (strobe window, done cycle,
// earliest next grant) and a compare process checks every DUT output
// against it on each falling edge. Directed accesses pin the model with
// hand-computed latencies, strobe counts and data; a randomized phase then
// drives both ports concurrently. Define DMEM_ARB_ALIGN_CHECK_EN for both
// the bench and the RTL to exercise the alignment check.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 2;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- memory
  logic [DW-1:0] tb_mem [0:255];

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0101);
  endfunction

  function automatic int widx(input logic [AW-1:0] a);
    return int'(a[9:2]);
  endfunction

  assign bus.mem_rdata = bus.mem_read ? tb_mem[bus.mem_addr[9:2]] : 32'h0BAD_0BAD;

  always @(posedge clk) begin
    if (bus.mem_write) tb_mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end

  // ---------------------------------------------------------------- scoreboard
  int n_cmp  = 0;
  int n_fail = 0;
  logic [1:0] exp_q[$];
  int   done_cyc_q[$];
  logic done_port_q[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_read"},  32'(bus.mem_read),  32'd0);
    chk({tag, "_mem_write"}, 32'(bus.mem_write), 32'd0);
    chk({tag, "_mem_addr"},  bus.mem_addr,       32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
    chk({tag, "_p0_done"},   32'(bus.p0_done),   32'd0);
    chk({tag, "_p1_done"},   32'(bus.p1_done),   32'd0);
    chk({tag, "_p0_rdata"},  bus.p0_rdata,       32'd0);
    chk({tag, "_p1_rdata"},  bus.p1_rdata,       32'd0);
    chk({tag, "_err"},       32'(bus.err),       32'd0);
  endtask

  // ---------------------------------------------------------------- model
  logic [DW-1:0] m_mem [0:255];
  logic [DW-1:0] exp_rd [2];
  int            cyc;
  int            free_at, s_first, s_last, done_at;
  bit            act, g_port, g_rd, g_err, last_p;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;

  initial begin
    cyc = 0; free_at = 0; s_first = 0; s_last = 0; done_at = -1;
    act = 0; g_port = 0; g_rd = 0; g_err = 0; last_p = 1;
    g_addr = '0; g_wdata = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act = 0; last_p = 1; exp_rd[0] = '0; exp_rd[1] = '0;
        free_at = cyc + 1;
        chk_all_zero("in_reset");
      end else begin
        bit e_strobe, e_done, r0, r1;
        e_strobe = act && !g_err && cyc >= s_first && cyc <= s_last;
        e_done   = act && cyc == done_at;
        if (e_done && !g_err) begin
          if (g_rd) exp_rd[g_port] = m_mem[widx(g_addr)];
          else      m_mem[widx(g_addr)] = g_wdata;
        end
        chk("mem_read",  32'(bus.mem_read),  32'(e_strobe && g_rd));
        chk("mem_write", 32'(bus.mem_write), 32'(e_strobe && !g_rd));
        if (e_strobe) chk("mem_addr", bus.mem_addr, g_addr);
        if (e_strobe && !g_rd) chk("mem_wdata", bus.mem_wdata, g_wdata);
        chk("p0_done",  32'(bus.p0_done), 32'(e_done && g_port == 1'b0));
        chk("p1_done",  32'(bus.p1_done), 32'(e_done && g_port == 1'b1));
        chk("p0_rdata", bus.p0_rdata, exp_rd[0]);
        chk("p1_rdata", bus.p1_rdata, exp_rd[1]);
        chk("err",      32'(bus.err), 32'(e_done && g_err));
        if (bus.p0_done) begin done_cyc_q.push_back(cyc); done_port_q.push_back(1'b0); end
        if (bus.p1_done) begin done_cyc_q.push_back(cyc); done_port_q.push_back(1'b1); end
        if (e_done) act = 0;
        // Arbitration on this cycle's inputs, if the block is free again.
        r0 = bus.p0_read | bus.p0_write;
        r1 = bus.p1_read | bus.p1_write;
        if (cyc >= free_at && (r0 || r1)) begin
          g_port  = (r0 && r1) ? !last_p : r1;
          last_p  = g_port;
          g_rd    = g_port ? bus.p1_read  : bus.p0_read;
          g_addr  = g_port ? bus.p1_addr  : bus.p0_addr;
          g_wdata = g_port ? bus.p1_wdata : bus.p0_wdata;
          g_err   = ALIGN && (g_addr[1:0] != 2'b00);
          act     = 1;
          s_first = cyc + 1;
          s_last  = cyc + 1 + W;
          done_at = g_err ? cyc + 1 : cyc + 2 + W;
          free_at = done_at + 1;
        end
      end
      cyc++;
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic drive(input int p, input bit rd, input bit wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      bus.p0_read = rd; bus.p0_write = wr; bus.p0_addr = a; bus.p0_wdata = d;
    end else begin
      bus.p1_read = rd; bus.p1_write = wr; bus.p1_addr = a; bus.p1_wdata = d;
    end
  endtask

  // Starts just after a rising edge; returns just after the edge that ends
  // the done cycle, with the port's request dropped.
  task automatic do_access(input int p, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int lat, output int n_rs, output int n_ws,
                           output logic [DW-1:0] rdata, output bit err_seen);
    drive(p, rd, wr, a, d);
    lat = 0; n_rs = 0; n_ws = 0; rdata = '0; err_seen = 0;
    forever begin
      @(negedge clk);
      if ((p == 0) ? bus.p0_done : bus.p1_done) begin
        rdata    = (p == 0) ? bus.p0_rdata : bus.p1_rdata;
        err_seen = bus.err;
        break;
      end
      if (bus.mem_read)  n_rs++;
      if (bus.mem_write) n_ws++;
      lat++;
      if (lat > 200) begin
        n_cmp++; n_fail++;
        $display("FAIL done_timeout: port %0d got no done within 200 cycles", p);
        break;
      end
    end
    @(posedge clk); #1;
    drive(p, 0, 0, '0, '0);
  endtask

  task automatic rand_port(input int p, input int n);
    int lat, rs, ws;
    logic [DW-1:0] rdata;
    bit e;
    for (int k = 0; k < n; k++) begin
      int gap, sel;
      logic [AW-1:0] a;
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      sel = $urandom_range(0, 9);
      a = 32'd1000 + 32'($urandom_range(0, 15)) * 32'd4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      do_access(p, sel < 5 || sel >= 8, sel >= 5, a, 32'($urandom()), lat, rs, ws, rdata, e);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- main
  initial begin
    int lat, rs, ws;
    logic [DW-1:0] rdata;
    bit e;

    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = init_word(i);
      m_mem[i]  = init_word(i);
    end
    tb_mem[widx(32'd1000)] = 32'd56;
    m_mem[widx(32'd1000)]  = 32'd56;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // p0 read of word 1000
    do_access(0, 1, 0, 32'd1000, '0, lat, rs, ws, rdata, e);
    chk("rd_latency", 32'(lat), 32'd4);
    chk("rd_strobes", 32'(rs), 32'd3);
    chk("rd_no_write", 32'(ws), 32'd0);
    chk("rd_data_56", rdata, 32'd56);

    // p1 write then read back at 2000
    do_access(1, 0, 1, 32'd2000, 32'hDEADBEEF, lat, rs, ws, rdata, e);
    chk("wr_latency", 32'(lat), 32'd4);
    chk("wr_strobes", 32'(ws), 32'd3);
    chk("wr_rdata_hold", rdata, 32'd0);
    do_access(1, 1, 0, 32'd2000, '0, lat, rs, ws, rdata, e);
    chk("wr_readback", rdata, 32'hDEADBEEF);

    // read+write together behaves as a read
    do_access(0, 1, 1, 32'd1004, 32'h1234_5678, lat, rs, ws, rdata, e);
    chk("rw_read_strobes", 32'(rs), 32'd3);
    chk("rw_write_strobes", 32'(ws), 32'd0);
    chk("rw_rdata", rdata, init_word(widx(32'd1004)));
    chk("rw_mem_unchanged", tb_mem[widx(32'd1004)], init_word(widx(32'd1004)));
    chk("p1_rdata_hold", bus.p1_rdata, 32'hDEADBEEF);

    // misaligned address
    do_access(0, 1, 0, 32'd1001, '0, lat, rs, ws, rdata, e);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    chk("mis_latency", 32'(lat), 32'd1);
    chk("mis_strobes", 32'(rs + ws), 32'd0);
    chk("mis_err", 32'(e), 32'd1);
    chk("mis_rdata_hold", rdata, init_word(widx(32'd1004)));
`else
    chk("mis_latency", 32'(lat), 32'd4);
    chk("mis_strobes", 32'(rs), 32'd3);
    chk("mis_err", 32'(e), 32'd0);
    chk("mis_rdata", rdata, 32'd56);
`endif

    // both ports reading back to back from reset: strict alternation
    do_reset();
    done_cyc_q.delete();
    done_port_q.delete();
    exp_q = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
    fork
      begin
        for (int k = 0; k < 3; k++)
          do_access(0, 1, 0, 32'd1008 + 32'(k) * 4, '0, lat, rs, ws, rdata, e);
      end
      begin
        int l1, r1, w1;
        logic [DW-1:0] d1;
        bit e1;
        for (int k = 0; k < 3; k++)
          do_access(1, 1, 0, 32'd1020 + 32'(k) * 4, '0, l1, r1, w1, d1, e1);
      end
    join
    chk("rr_done_count", 32'(done_port_q.size()), 32'd6);
    for (int i = 0; i < done_port_q.size() && i < 6; i++) begin
      chk("rr_order", 32'(done_port_q[i]), 32'(exp_q.pop_front()));
      if (i > 0) chk("rr_spacing", 32'(done_cyc_q[i] - done_cyc_q[i-1]), 32'(W + 3));
    end

    // reset pulled in the middle of an access
    do_reset();
    drive(0, 1, 0, 32'd1000, '0);
    @(negedge clk);
    @(negedge clk);
    chk("busy_before_reset", 32'(bus.mem_read), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    drive(0, 0, 0, '0, '0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    done_port_q.delete();
    done_cyc_q.delete();
    fork
      begin
        do_access(0, 1, 0, 32'd1008, '0, lat, rs, ws, rdata, e);
      end
      begin
        int l1, r1, w1;
        logic [DW-1:0] d1;
        bit e1;
        do_access(1, 1, 0, 32'd1012, '0, l1, r1, w1, d1, e1);
        chk("post_reset_p1_latency", 32'(l1), 32'(2 * W + 5));
      end
    join
    chk("post_reset_p0_latency", 32'(lat), 32'(W + 2));
    chk("post_reset_first_port", (done_port_q.size() > 0) ? 32'(done_port_q[0]) : 32'hFFFF_FFFF, 32'd0);

    // randomized traffic on both ports
    @(posedge clk); #1;
    fork
      rand_port(0, 60);
      rand_port(1, 60);
    join
    repeat (10) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and access sequencer in front of the single-port data memory.
- Port 0 is the pipeline MEM stage; port 1 is the loader/debug port used to preload or inspect data memory.
- The block serialises accesses, drives the memory strobes for a fixed number of wait states and returns read data with a one-cycle done pulse.
- Port 0 derives its pipeline stall from `!p0_done` while requesting.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- WAIT_CYCLES, 0, extra cycles the memory strobes are held beyond the first access cycle (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p0_read  in  1  MEM-stage read request.
- p0_write  in  1  MEM-stage write request.
- p0_addr  in  AW  MEM-stage byte address.
- p0_wdata  in  DW  MEM-stage write data.
- p0_rdata  out  DW  read data returned to port 0.
- p0_done  out  1  one-cycle pulse: port 0 access complete.
- p1_read  in  1  loader read request.
- p1_write  in  1  loader write request.
- p1_addr  in  AW  loader address.
- p1_wdata  in  DW  loader write data.
- p1_rdata  out  DW  read data returned to port 1.
- p1_done  out  1  one-cycle pulse: port 1 access complete.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid while mem_read is high.
- err  out  1  see Optional Feature; tied 0 when the feature is off.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0, state IDLE, round-robin pointer `last` = 1 (port 0 wins first), wait counter 0.
- A requester holds read/write and operands stable until its done pulse. Request = read | write.
- If read and write are both high, the access is a read (read has priority).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any request is present, register the grant, operands and op; counter = WAIT_CYCLES; go to BUSY.
  - If both ports request, grant the port != `last`; then `last` = granted port.
  - Otherwise remain in IDLE with the strobes low.
- BUSY:
  - mem_read or mem_write high (exactly one), with mem_addr/mem_wdata taken from the latched operands.
  - When counter = 0: on a read, capture mem_rdata into the granted port's rdata register; go to DONE. Otherwise decrement the counter.
- DONE:
  - Strobes low; pulse the granted port's done for exactly one cycle; go to IDLE.
  - Requests seen during DONE are not arbitrated until the next IDLE cycle.
- Latency: request sampled in IDLE at cycle t.
  - Strobes are high cycles t+1 .. t+1+WAIT_CYCLES.
  - done pulses at cycle t+2+WAIT_CYCLES.
  - Minimum request-to-request period is WAIT_CYCLES+3.
- rdata registers hold their value until the next read on the same port. Writes do not change rdata.
- A request withdrawn mid-access does not abort it: the access completes and done still pulses.
- Reset asserted mid-access returns immediately to reset values. The memory write may be partial; this is not guaranteed.
- The address is passed through unmodified (word or byte interpretation belongs to the memory).

Optional Feature:
- Macro: DMEM_ARB_ALIGN_CHECK_EN.
- Defined:
  - A granted access with `addr[1:0] != 0` never raises a strobe.
  - The FSM goes IDLE -> DONE directly; done pulses; err is high in the same cycle as done.
  - rdata is unchanged.
- Undefined: err is constant 0 and all addresses are accessed as given.

Decomposition:
- Package dmem_arb_pkg:
  - State enum {IDLE, BUSY, DONE}.
  - Port index constants PORT_MEM = 0, PORT_LDR = 1.
  - Op enum {OP_RD, OP_WR}.
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter. Inputs: req[1:0], last. Outputs: gnt[1:0] (one-hot), gnt_idx.

Test Plan:
- WAIT_CYCLES=0, memory word 1000 = 56; p0_read with addr 1000 at cycle 0 -> mem_read high in cycle 1; p0_done in cycle 2; p0_rdata = 56.
- WAIT_CYCLES=2; p1_write with addr 2000, wdata 0xDEADBEEF, then p1_read addr 2000 -> mem_write high 3 cycles; first p1_done at cycle 4; second read returns 0xDEADBEEF.
- Both ports request reads continuously from reset -> grants alternate p0, p1, p0, p1; done pulses every 3 cycles at WAIT_CYCLES=0.
- p0_read and p0_write both high with addr 1004 -> only mem_read asserts; memory contents unchanged.
- rst_n pulled low during BUSY -> all outputs 0 asynchronously; after release, p0 wins the first contended grant.
- With DMEM_ARB_ALIGN_CHECK_EN, p0_read addr 1001 -> no strobe; p0_done and err high in cycle 1; p0_rdata unchanged.
